// File: rtl/stopwatch_timer_core_if.sv
// Control/status bundle between the stopwatch core and its board-level driver.
// The master drives the pulses and presets; the slave (the core) returns status and display pins.
interface stopwatch_timer_core_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic       load;
  logic       mode_down;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       running;
  logic       lap_active;
  logic       expired;
  logic [7:0] an;
  logic [7:0] seg;

  modport master (
    output start_stop, lap, clear, load, mode_down, preset_min, preset_sec,
    input  running, lap_active, expired, an, seg
  );

  modport slave (
    input  start_stop, lap, clear, load, mode_down, preset_min, preset_sec,
    output running, lap_active, expired, an, seg
  );
endinterface

// File: rtl/stopwatch_timer_core.sv
// MM:SS.hh stopwatch / countdown timer kept as six BCD digits, with lap freeze
// and a registered, multiplexed drive for an active-low 8-digit seven-segment display.
module stopwatch_timer_core #(
  parameter int CLK_HZ   = 5_000_000,
  parameter int TICK_HZ  = 100,
  parameter int SCAN_DIV = 2500,
  parameter int MIN_MAX  = 59
) (
  input  logic                   clk,
  input  logic                   reset,
  stopwatch_timer_core_if.slave  bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP  = PW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_TOP = SW'(SCAN_DIV - 1);
  localparam logic [7:0]    MIN_BCD  = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  // Digit i of the time is also display index i: 0=hundredths LSD ... 5=minutes MSD.
  typedef logic [5:0][3:0] bcd_time_t;

  state_t          state_q, state_d;
  logic            lap_q, lap_d;
  logic            exp_q, exp_d;
  logic            down_q, down_d;
  logic [PW-1:0]   pre_q, pre_d;
  bcd_time_t       time_q, time_d;
  bcd_time_t       snap_q, snap_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;

  logic            run;
  logic            tick;
  logic            load_ok;
  bcd_time_t       disp;
  logic [3:0]      digit;

  function automatic bcd_time_t bcd_up(input bcd_time_t t);
    bcd_time_t r;
    logic      c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i] == ((i == 3) ? 4'd5 : 4'd9)) r[i] = 4'd0;
        else begin
          r[i] = r[i] + 4'd1;
          c    = 1'b0;
        end
      end
    end
    if (c) begin
      if ({r[5], r[4]} == MIN_BCD) begin
        r[5] = 4'd0;
        r[4] = 4'd0;
      end else if (r[4] == 4'd9) begin
        r[4] = 4'd0;
        r[5] = r[5] + 4'd1;
      end else begin
        r[4] = r[4] + 4'd1;
      end
    end
    return r;
  endfunction

  // Borrow chain; minutes are only borrowed from when the lower four digits are
  // all zero, which implies non-zero minutes because zero itself is held.
  function automatic bcd_time_t bcd_dn(input bcd_time_t t);
    bcd_time_t r;
    logic      b;
    r = t;
    b = (t != '0);
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[i] == 4'd0) r[i] = (i == 3) ? 4'd5 : 4'd9;
        else begin
          r[i] = r[i] - 4'd1;
          b    = 1'b0;
        end
      end
    end
    if (b) begin
      if (r[4] == 4'd0) begin
        r[4] = 4'd9;
        r[5] = r[5] - 4'd1;
      end else begin
        r[4] = r[4] - 4'd1;
      end
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b100_0000;
      4'd1:    return 7'b111_1001;
      4'd2:    return 7'b010_0100;
      4'd3:    return 7'b011_0000;
      4'd4:    return 7'b001_1001;
      4'd5:    return 7'b001_0010;
      4'd6:    return 7'b000_0010;
      4'd7:    return 7'b111_1000;
      4'd8:    return 7'b000_0000;
      4'd9:    return 7'b001_0000;
      default: return 7'b111_1111;
    endcase
  endfunction

  assign run  = (state_q == ST_RUN);
  assign tick = run && (pre_q == PRE_TOP);

  assign load_ok = (bus.preset_min[7:4] <= 4'd9) && (bus.preset_min[3:0] <= 4'd9) &&
                   (bus.preset_sec[3:0] <= 4'd9) && (bus.preset_sec <= 8'h59) &&
                   (bus.preset_min <= MIN_BCD);

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    exp_d   = 1'b0;
    down_d  = down_q;
    pre_d   = pre_q;
    time_d  = time_q;
    snap_d  = snap_q;

    if (run) pre_d = tick ? '0 : pre_q + 1'b1;

    // Tick first; a same-cycle stop below still keeps the advanced time.
    if (tick) begin
      if (down_q) begin
        time_d = bcd_dn(time_q);
        if (time_d == '0) begin
          state_d = ST_STOP;
          exp_d   = 1'b1;
        end
      end else begin
        time_d = bcd_up(time_q);
      end
    end

    if (bus.clear) begin
      state_d = ST_STOP;
      lap_d   = 1'b0;
      time_d  = '0;
      pre_d   = '0;
    end else if (bus.load) begin
      if (!run && load_ok) begin
        time_d = {bus.preset_min, bus.preset_sec, 8'h00};
        pre_d  = '0;
      end
    end else if (bus.start_stop) begin
      if (run) begin
        state_d = ST_STOP;
      end else if (!(bus.mode_down && time_q == '0)) begin
        state_d = ST_RUN;
        down_d  = bus.mode_down;
      end
    end else if (bus.lap) begin
      if (run) begin
        lap_d = !lap_q;
        if (!lap_q) snap_d = time_q;
      end
    end
  end

  assign disp  = lap_q ? snap_q : time_q;
  assign digit = disp[idx_q];

  always_comb begin
    scan_d = (scan_q == SCAN_TOP) ? '0 : scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_TOP) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    // an and seg both come from idx_q so they always change on the same edge.
    an_d  = {2'b11, ~(6'b00_0001 << idx_q)};
    seg_d = {!((idx_q == 3'd2) || (idx_q == 3'd4)), seg7(digit)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
      lap_q   <= 1'b0;
      exp_q   <= 1'b0;
      down_q  <= 1'b0;
      pre_q   <= '0;
      time_q  <= '0;
      snap_q  <= '0;
      scan_q  <= '0;
      idx_q   <= 3'd0;
      an_q    <= 8'hFE;
      seg_q   <= 8'hC0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
      exp_q   <= exp_d;
      down_q  <= down_d;
      pre_q   <= pre_d;
      time_q  <= time_d;
      snap_q  <= snap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.running    = run;
  assign bus.lap_active = lap_q;
  assign bus.expired    = exp_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;

endmodule
